// File: rtl/alu_xbar_pe_pkg.sv
// Shared types and configuration-word layout for the crossbar/ALU processing element.
package alu_xbar_pe_pkg;

   localparam int CFG_W = 13;

   localparam int CFG_SEL3_LSB = 11;
   localparam int CFG_SEL2_LSB = 9;
   localparam int CFG_SEL1_LSB = 7;
   localparam int CFG_SEL0_LSB = 5;
   localparam int CFG_OSEL_BIT = 4;
   localparam int CFG_OP_LSB   = 0;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SHL  = 4'd6,
      OP_SHR  = 4'd7,
      OP_SRA  = 4'd8,
      OP_EQ   = 4'd9,
      OP_SLT  = 4'd10,
      OP_ULT  = 4'd11,
      OP_PASA = 4'd12,
      OP_PASB = 4'd13,
      OP_SMIN = 4'd14,
      OP_SMAX = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_IN0 = 2'd0,
      SRC_IN1 = 2'd1,
      SRC_ALU = 2'd2,
      SRC_EXT = 2'd3
   } xbar_src_e;

   // Field order mirrors the bit positions above, MSB first.
   typedef struct packed {
      logic [1:0] sel3;
      logic [1:0] sel2;
      logic [1:0] sel1;
      logic [1:0] sel0;
      logic       osel;
      alu_op_e    op;
   } cfg_t;

endpackage

// File: rtl/alu_xbar_pe_alu_core.sv
// Registered two-operand ALU: one cycle from operands/opcode to q, all arithmetic modulo 2^size.
module alu_core
   import alu_xbar_pe_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      op,
   input  logic [size-1:0] a,
   input  logic [size-1:0] b,
   output logic [size-1:0] q
);

   localparam int        SH_W    = $clog2(size);
   localparam logic [4:0] SH_MASK = (SH_W >= 5) ? 5'h1f : 5'((1 << SH_W) - 1);

   logic signed [size-1:0] a_s;
   logic signed [size-1:0] b_s;
   logic [4:0]             sh_amt;
   logic [size-1:0]        res_p0;

   function automatic logic [size-1:0] flag_ext(input logic f);
      flag_ext = {{(size-1){1'b0}}, f};
   endfunction

   function automatic logic [size-1:0] smin(input logic signed [size-1:0] x,
                                            input logic signed [size-1:0] y);
      smin = (x < y) ? x : y;
   endfunction

   function automatic logic [size-1:0] smax(input logic signed [size-1:0] x,
                                            input logic signed [size-1:0] y);
      smax = (x < y) ? y : x;
   endfunction

   assign a_s    = $signed(a);
   assign b_s    = $signed(b);
   assign sh_amt = b[4:0] & SH_MASK;

   always_comb begin
      res_p0 = '0;
      case (alu_op_e'(op))
         OP_ADD:  res_p0 = a + b;
         OP_SUB:  res_p0 = a - b;
         OP_MUL:  res_p0 = a * b;
         OP_AND:  res_p0 = a & b;
         OP_OR:   res_p0 = a | b;
         OP_XOR:  res_p0 = a ^ b;
         OP_SHL:  res_p0 = a << sh_amt;
         OP_SHR:  res_p0 = a >> sh_amt;
         OP_SRA:  res_p0 = a_s >>> sh_amt;
         OP_EQ:   res_p0 = flag_ext(a == b);
         OP_SLT:  res_p0 = flag_ext(a_s < b_s);
         OP_ULT:  res_p0 = flag_ext(a < b);
         OP_PASA: res_p0 = a;
         OP_PASB: res_p0 = b;
         OP_SMIN: res_p0 = smin(a_s, b_s);
         OP_SMAX: res_p0 = smax(a_s, b_s);
         default: res_p0 = '0;
      endcase
   end

   // p0 -> p1: result register (this is alu_q at the tile level)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= res_p0;
   end

endmodule

// File: rtl/alu_xbar_pe.sv
// CGRA processing-element slice: serial config chain, 4x4 input crossbar, registered ALU,
// and a 2:1 output selector between the ALU result and an external unit.
module alu_xbar_pe
   import alu_xbar_pe_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            config_en,
   input  logic            config_in,
   output logic            config_out,
   input  logic [size-1:0] in0,
   input  logic [size-1:0] in1,
   input  logic [size-1:0] ext_in,
   output logic [size-1:0] out0,
   output logic [size-1:0] fu_aux0,
   output logic [size-1:0] fu_aux1
);

   logic [CFG_W-1:0] cfg;
   cfg_t             cfg_f;
   logic [size-1:0]  alu_q;
   logic [size-1:0]  xb_a_p0;
   logic [size-1:0]  xb_b_p0;

   function automatic logic [size-1:0] xbar_pick(input logic [1:0]      sel,
                                                 input logic [size-1:0] d_in0,
                                                 input logic [size-1:0] d_in1,
                                                 input logic [size-1:0] d_alu,
                                                 input logic [size-1:0] d_ext);
      case (xbar_src_e'(sel))
         SRC_IN0: xbar_pick = d_in0;
         SRC_IN1: xbar_pick = d_in1;
         SRC_ALU: xbar_pick = d_alu;
         SRC_EXT: xbar_pick = d_ext;
         default: xbar_pick = d_in0;
      endcase
   endfunction

   // Fields take effect as soon as they land, so a partially shifted word is live.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         cfg <= '0;
      else if (config_en) cfg <= {cfg[CFG_W-2:0], config_in};
   end

   assign cfg_f      = cfg_t'(cfg);
   assign config_out = cfg[CFG_W-1];

   // p0: crossbar; the ALU feedback source is alu_q, so there is no combinational loop
   assign xb_a_p0 = xbar_pick(cfg_f.sel0, in0, in1, alu_q, ext_in);
   assign xb_b_p0 = xbar_pick(cfg_f.sel1, in0, in1, alu_q, ext_in);
   assign fu_aux0 = xbar_pick(cfg_f.sel2, in0, in1, alu_q, ext_in);
   assign fu_aux1 = xbar_pick(cfg_f.sel3, in0, in1, alu_q, ext_in);

   alu_core #(
      .size (size)
   ) u_alu_core (
      .clk   (clk),
      .reset (reset),
      .op    (cfg_f.op),
      .a     (xb_a_p0),
      .b     (xb_b_p0),
      .q     (alu_q)
   );

   // p1: output selector
   assign out0 = cfg_f.osel ? ext_in : alu_q;

endmodule

// File: tb/tb_alu_xbar_pe.sv
// Scoreboard bench for alu_xbar_pe: expected ALU results queued on drive, popped one cycle later.
module tb_alu_xbar_pe;
   import alu_xbar_pe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        config_en;
   logic        config_in;
   logic        config_out;
   logic [31:0] in0;
   logic [31:0] in1;
   logic [31:0] ext_in;
   logic [31:0] out0;
   logic [31:0] fu_aux0;
   logic [31:0] fu_aux1;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   alu_xbar_pe #(.size(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .config_en  (config_en),
      .config_in  (config_in),
      .config_out (config_out),
      .in0        (in0),
      .in1        (in1),
      .ext_in     (ext_in),
      .out0       (out0),
      .fu_aux0    (fu_aux0),
      .fu_aux1    (fu_aux1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] mk_cfg(input logic [1:0] s3, input logic [1:0] s2,
                                          input logic [1:0] s1, input logic [1:0] s0,
                                          input logic osel, input logic [3:0] op);
      mk_cfg = {s3, s2, s1, s0, osel, op};
   endfunction

   // Independent reference: signed compares via MSB flip, arithmetic shift via fill mask.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0]  s;
      logic [31:0] af;
      logic [31:0] bf;
      s  = b[4:0];
      af = a ^ 32'h8000_0000;
      bf = b ^ 32'h8000_0000;
      case (op)
         4'd0:  ref_alu = a + b;
         4'd1:  ref_alu = a + ~b + 32'd1;
         4'd2:  ref_alu = a * b;
         4'd3:  ref_alu = a & b;
         4'd4:  ref_alu = a | b;
         4'd5:  ref_alu = a ^ b;
         4'd6:  ref_alu = a << s;
         4'd7:  ref_alu = a >> s;
         4'd8:  ref_alu = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd9:  ref_alu = (a == b) ? 32'd1 : 32'd0;
         4'd10: ref_alu = (af < bf) ? 32'd1 : 32'd0;
         4'd11: ref_alu = (a < b) ? 32'd1 : 32'd0;
         4'd12: ref_alu = a;
         4'd13: ref_alu = b;
         4'd14: ref_alu = (af < bf) ? a : b;
         default: ref_alu = (af < bf) ? b : a;
      endcase
   endfunction

   task automatic shift_cfg(input logic [12:0] v);
      for (int i = 12; i >= 0; i--) begin
         config_en = 1'b1;
         config_in = v[i];
         @(posedge clk); #1;
      end
      config_en = 1'b0;
      config_in = 1'b0;
   endtask

   task automatic alu_step(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] e, input logic [31:0] exp);
      in0    = a0;
      in1    = a1;
      ext_in = e;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      check_val(tag, out0, exp_q.pop_front());
   endtask

   task automatic pulse_reset();
      in0 = '0; in1 = '0; ext_in = '0;
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [19:0] pat;
      logic        exp_co;
      int          k;

      reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
      in0 = '0; in1 = '0; ext_in = '0;
      #12;
      check_val("reset_out0", out0, 32'h0);
      check_val("reset_cfgout", {31'h0, config_out}, 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      alu_step("default_add", 32'd3, 32'd0, 32'd0, 32'd6);

      // Config load plus add, aux ports routed to ext_in
      shift_cfg(mk_cfg(2'd3, 2'd3, 2'd1, 2'd0, 1'b0, OP_ADD));
      check_val("cfg_msb", {31'h0, config_out}, 32'h1);
      in0 = 32'd5; in1 = 32'd7; ext_in = 32'h1234_5678;
      #1;
      check_val("fu_aux0_ext", fu_aux0, 32'h1234_5678);
      check_val("fu_aux1_ext", fu_aux1, 32'h1234_5678);
      alu_step("add_5_7", 32'd5, 32'd7, 32'h1234_5678, 32'd12);

      // Asynchronous reset in the middle of operation (alu_q=12, cfg[12]=1)
      #1;
      reset = 1'b0;
      #1;
      check_val("midrst_out0", out0, 32'h0);
      check_val("midrst_cfgout", {31'h0, config_out}, 32'h0);
      reset = 1'b1;
      in0 = 32'd3;
      #1;
      check_val("midrst_aux0", fu_aux0, 32'd3);
      alu_step("midrst_add", 32'd3, 32'd0, 32'd0, 32'd6);

      // Wrap and signed ops
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, OP_SUB));
      alu_step("sub_wrap", 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF);
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, OP_SLT));
      alu_step("slt_neg", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, OP_ULT));
      alu_step("ult_big", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, OP_SRA));
      alu_step("sra_4", 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);

      // All opcodes against the reference with random operands
      for (int op = 0; op < 16; op++) begin
         shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 4'(op)));
         for (int j = 0; j < 4; j++) begin
            ra = $urandom;
            rb = (j == 0) ? ra : ((j == 1) ? (ra ^ 32'h8000_0000) : $urandom);
            alu_step($sformatf("op%0d_r%0d", op, j), ra, rb, 32'd0, ref_alu(4'(op), ra, rb));
         end
      end

      // Feedback accumulate: zero data while shifting keeps alu_q at 0
      @(posedge clk); #1;
      pulse_reset();
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, OP_ADD));
      for (int i = 1; i <= 4; i++) alu_step($sformatf("acc_%0d", i), 32'd0, 32'd1, 32'd0, 32'(i));

      // Output select: ext_in straight through, then back to alu_q
      in0 = 32'd2; in1 = 32'd3; ext_in = 32'd0;
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, OP_ADD));
      ext_in = 32'hDEAD_BEEF;
      #1;
      check_val("osel_ext", out0, 32'hDEAD_BEEF);
      ext_in = 32'h0BAD_F00D;
      #1;
      check_val("osel_ext2", out0, 32'h0BAD_F00D);
      shift_cfg(mk_cfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, OP_ADD));
      alu_step("osel_alu", 32'd2, 32'd3, 32'h0BAD_F00D, 32'd5);

      // Config chain pass-through with a 5-cycle hold gap
      @(posedge clk); #1;
      pulse_reset();
      @(posedge clk); #1;
      pat = 20'b1011_0010_1110_0011_0101;
      k   = 0;
      for (int j = 0; j < 20; j++) begin
         config_en = 1'b1;
         config_in = pat[19-j];
         @(posedge clk); #1;
         k++;
         exp_co = (k >= 13) ? pat[19-(k-13)] : 1'b0;
         check_val($sformatf("chain_%0d", k), {31'h0, config_out}, {31'h0, exp_co});
         if (k == 16) begin
            config_en = 1'b0;
            for (int g = 0; g < 5; g++) begin
               config_in = ~config_in;
               @(posedge clk); #1;
               check_val($sformatf("chain_hold_%0d", g), {31'h0, config_out}, {31'h0, exp_co});
            end
         end
      end
      config_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_xbar_pe.md
# alu_xbar_pe

Configurable processing-element slice: a 4x4 fully-connected input crossbar feeds a registered two-operand ALU, and a 2x1 output selector chooses the ALU result or an external functional-unit result. Static configuration is shifted in serially on the system clock. Tiles use it inside the CGRA array; the external `ext_in` / `fu_aux*` ports connect to a neighbouring unit such as the tile memory.

## Interface
- `size`, default 32: datapath width in bits, minimum 8.
- `clk` input, 1 bit: single clock. All state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. Clears all state.
- `config_en` input, 1 bit: configuration shift enable.
- `config_in` input, 1 bit: serial configuration data.
- `config_out` output, 1 bit: serial configuration out, equal to `cfg[12]`, for chaining.
- `in0`, `in1` input, `size` bits: tile data inputs.
- `ext_in` input, `size` bits: result from the external unit.
- `out0` output, `size` bits: tile output.
- `fu_aux0`, `fu_aux1` output, `size` bits: crossbar outputs 2 and 3, routed to the external unit.

## Operation
- **Config register.** `cfg[12:0]`. When `config_en` is high: `cfg <= {cfg[11:0], config_in}`. Otherwise it holds. The first bit shifted in ends at bit 12.
- **Config fields:**
  - `[12:11]` sel of xbar out3
  - `[10:9]` sel of xbar out2
  - `[8:7]` sel of xbar out1
  - `[6:5]` sel of xbar out0
  - `[4]` output select
  - `[3:0]` ALU opcode
- **Input crossbar** (combinational). xbar inputs: 0=`in0`, 1=`in1`, 2=`alu_q` (feedback), 3=`ext_in`. Each of the 4 xbar outputs takes the input indexed by its 2-bit sel.
  - xbar out0/out1 drive ALU operands a/b.
  - xbar out2/out3 drive `fu_aux0`/`fu_aux1`.
- **ALU.** Registered: `alu_q <= f(op, a, b)` every cycle. All arithmetic is modulo 2^size. Shift amount is `b[4:0]`, masked to log2(size) bits. Compare results are zero-extended 0/1.
  - 0 add
  - 1 sub (a-b)
  - 2 mul (low `size` bits)
  - 3 and
  - 4 or
  - 5 xor
  - 6 shl
  - 7 logical shr
  - 8 arithmetic shr
  - 9 eq
  - 10 signed lt
  - 11 unsigned lt
  - 12 pass a
  - 13 pass b
  - 14 signed min
  - 15 signed max
- **Output selector** (combinational): `out0 = cfg[4] ? ext_in : alu_q`.
- **Reconfiguration while running.** Fields act immediately, including partially shifted values. Software must hold data idle or ignore outputs during shifting.

## Timing
- **Reset** (asynchronous, active-low): `cfg=0`, `alu_q=0`. Hence `out0=0` and `config_out=0`. The default routing is all xbar outputs = `in0`, op=add.
- **ALU latency.** Exactly 1 cycle from operands to `out0` when `cfg[4]=0`.
- **Combinational paths:**
  - `ext_in` → `out0`
  - `in*`/`ext_in` → `fu_aux*`
  - No combinational loop: the feedback passes through `alu_q`.
- **Config serial latency.** A bit appears on `config_out` 13 enabled shifts after entry. Gaps with `config_en=0` are allowed.
- **Simultaneous events.**
  - Reset dominates `config_en`.
  - In a cycle where cfg changes, the ALU captures using the pre-edge opcode and selects.

## Structure
- Shared package:
  - opcode enum (16 values above)
  - xbar source enum (IN0, IN1, ALU, EXT)
  - cfg field bit positions
  - `CFG_W=13` constant
- Natural sub-module: `alu_core`, parameterised on `size`: opcode plus a/b in, registered result out, with `clk`/`reset`.
- Crossbar, output selector and config shift register stay inline.

## Test plan
- **Reset:** assert `reset=0` mid-operation with nonzero `alu_q` → `out0=0` and `config_out=0` immediately. After release, `in0=3` → `out0=6` next cycle (add, a=b=in0).
- **Config load plus add:** shift 13 bits MSB-first so that sels are out0=0, out1=1, out2=3, out3=3, `cfg[4]=0`, op=0. Then drive `in0=5`, `in1=7` → `out0=12` one cycle later; `fu_aux0 = fu_aux1 = ext_in`.
- **Wrap and signed ops:**
  - sub with `in0=0`, `in1=1` → `0xFFFFFFFF`
  - op 10 with a=`0xFFFFFFFF`, b=1 → 1
  - op 11 with the same operands → 0
  - op 8 with a=`0x80000000`, b=4 → `0xF8000000`
- **Feedback accumulate:** out0 sel=2, out1 sel=1, add, `in1=1` from the `alu_q=0` start → `out0` reads 1, 2, 3, 4 on successive cycles.
- **Output select:** `cfg[4]=1`, `ext_in=0xDEADBEEF` → `out0=0xDEADBEEF` same cycle. Flip back to 0 → `out0` shows `alu_q`.
- **Chain pass-through:** shift pattern `1,0,1,1,...` → `config_out` replays it 13 enabled cycles later. Holding `config_en=0` for 5 cycles leaves `cfg` and `config_out` unchanged.
